// File: rtl/shift_pkg.sv
// Shared definitions for the shift_arb / shift_mux slice.
package shift_pkg;

    localparam int unsigned SH_W   = 32;
    localparam int unsigned SH_SAW = 5;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } shift_arb_state_t;

endpackage

// File: rtl/shift_mux.sv
// Combinational 32-bit barrel shifter: left, logical right or arithmetic right.
module shift_mux
    import shift_pkg::*;
(
    input  logic [SH_W-1:0]   d_i,
    input  logic [SH_SAW-1:0] sa_i,
    input  logic              right_i,
    input  logic              arith_i,
    output logic [SH_W-1:0]   y_o
);

    logic signed [SH_W-1:0] sra_v;

    // Arithmetic shift kept in its own signed variable so the sign fill survives.
    always_comb begin
        sra_v = $signed(d_i) >>> sa_i;
    end

    // Select shift flavour.
    always_comb begin
        y_o = d_i << sa_i;
        if (right_i) begin
            if (arith_i) begin
                y_o = sra_v;
            end else begin
                y_o = d_i >> sa_i;
            end
        end
    end

endmodule

// File: rtl/shift_arb.sv
// Round-robin arbiter/sequencer in front of the shared shift_mux.
// Macro SHIFT_ARB_ROR_EN: when defined, op 11 is a rotate right done as two
// shifter passes (PASS2); when undefined, op 11 behaves as SRL in one pass.
module shift_arb
    import shift_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*SH_W-1:0]   req_d,
    input  logic [NREQ*SH_SAW-1:0] req_sa,
    input  logic [NREQ*2-1:0]      req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [SH_W-1:0]        rsp_data
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    shift_arb_state_t state_q, state_d;

    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [SH_W-1:0]   d_q, d_d;
    logic [SH_SAW-1:0] sa_q, sa_d;
    logic [1:0]        op_q, op_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [SH_W-1:0]   r_q, r_d;

    logic              gnt_found;
    logic [PTRW-1:0]   gnt_idx;
    logic [SH_W-1:0]   sel_d;
    logic [SH_SAW-1:0] sel_sa;
    logic [1:0]        sel_op;
    logic              accept;

    logic [SH_SAW-1:0] sh_sa;
    logic              sh_right;
    logic              sh_arith;
    logic [SH_W-1:0]   sh_y;

    // Round-robin search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_d     = '0;
        sel_sa    = '0;
        sel_op    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTRW'(idx);
                sel_d     = req_d[idx*SH_W +: SH_W];
                sel_sa    = req_sa[idx*SH_SAW +: SH_SAW];
                sel_op    = req_op[idx*2 +: 2];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PASS1;
                end
            end
            ST_PASS1: begin
                state_d = ST_RESP;
`ifdef SHIFT_ARB_ROR_EN
                if (op_q == SH_ROR) begin
                    state_d = ST_PASS2;
                end
`endif
            end
`ifdef SHIFT_ARB_ROR_EN
            ST_PASS2: begin
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake and shifter control for the current pass.
    always_comb begin
        accept    = (state_q == ST_IDLE) && gnt_found && !rst;
        req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
        rsp_valid = (state_q == ST_RESP);
        sh_sa     = sa_q;
        sh_right  = (op_q != SH_SLL);
        sh_arith  = (op_q == SH_SRA);
`ifdef SHIFT_ARB_ROR_EN
        // Second rotate pass: left shift by (32 - sa) mod 32 supplies the wrapped bits.
        if (state_q == ST_PASS2) begin
            sh_sa    = SH_SAW'(6'd32 - {1'b0, sa_q});
            sh_right = 1'b0;
            sh_arith = 1'b0;
        end
`endif
    end

    // Operand latch on accept, pointer advance, result accumulation per pass.
    always_comb begin
        ptr_d = ptr_q;
        d_d   = d_q;
        sa_d  = sa_q;
        op_d  = op_q;
        id_d  = id_q;
        r_d   = r_q;
        if (accept) begin
            ptr_d = PTRW'((32'(gnt_idx) + 32'd1) % NREQ);
            d_d   = sel_d;
            sa_d  = sel_sa;
            op_d  = sel_op;
            id_d  = IDW'(gnt_idx);
        end
        if (state_q == ST_PASS1) begin
            r_d = sh_y;
        end
`ifdef SHIFT_ARB_ROR_EN
        if (state_q == ST_PASS2) begin
            r_d = r_q | sh_y;
        end
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            d_q   <= '0;
            sa_q  <= '0;
            op_q  <= '0;
            id_q  <= '0;
            r_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            d_q   <= d_d;
            sa_q  <= sa_d;
            op_q  <= op_d;
            id_q  <= id_d;
            r_q   <= r_d;
        end
    end

    shift_mux u_shift (
        .d_i    (d_q),
        .sa_i   (sh_sa),
        .right_i(sh_right),
        .arith_i(sh_arith),
        .y_o    (sh_y)
    );

    assign rsp_id   = id_q;
    assign rsp_data = r_q;

endmodule

// File: tb/tb_shift_arb.sv
// Testbench for shift_arb (NREQ=2). Honours SHIFT_ARB_ROR_EN for rotate expectations.
module tb_shift_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_d;
    logic [NREQ*5-1:0]    req_sa;
    logic [NREQ*2-1:0]    req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;

    shift_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_d    (req_d),
        .req_sa   (req_sa),
        .req_op   (req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side pending transactions (held until accepted).
    logic [NREQ-1:0] pend;
    logic [31:0]     pd  [NREQ];
    logic [4:0]      psa [NREQ];
    logic [1:0]      pop [NREQ];

    // Reference model: idle(0) / busy(1) with remaining passes / responding(2).
    int          m_phase = 0;
    int          m_rem   = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    logic [31:0] m_data  = '0;

    int cyc = 0;
    int acc_q[$];
    int acc_cyc[$];

    logic           last_rv;
    logic [31:0]    last_data;
    logic [IDW-1:0] last_id;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sa, input logic [1:0] op);
`ifdef SHIFT_ARB_ROR_EN
        logic [63:0] dd;
`endif
        case (op)
            2'd0: return d << sa;
            2'd1: return d >> sa;
            2'd2: return (d >> sa) | (d[31] ? ~(32'hFFFF_FFFF >> sa) : 32'h0);
            default: begin
`ifdef SHIFT_ARB_ROR_EN
                dd = {d, d} >> sa;
                return dd[31:0];
`else
                return d >> sa;
`endif
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op);
`ifdef SHIFT_ARB_ROR_EN
        return (op == 2'd3) ? 2 : 1;
`else
        return 1;
`endif
    endfunction

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_d[32*i +: 32] = pd[i];
            req_sa[5*i +: 5]  = psa[i];
            req_op[2*i +: 2]  = pop[i];
        end
    endtask

    // One clock: drive, check mid-cycle against the model, advance the model at the edge.
    task automatic step();
        int g;
        logic [NREQ-1:0] eg;
        drive();
        @(negedge clk);
        g  = -1;
        eg = '0;
        if (m_phase == 0 && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        last_rv   = rsp_valid;
        last_data = rsp_data;
        last_id   = rsp_id;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
        end else begin
            case (m_phase)
                0: if (g >= 0) begin
                    m_data  = ref_shift(pd[g], psa[g], pop[g]);
                    m_id    = g;
                    m_rem   = ref_lat(pop[g]);
                    m_phase = 1;
                    m_ptr   = (g + 1) % NREQ;
                    pend[g] = 1'b0;
                    acc_q.push_back(g);
                    acc_cyc.push_back(cyc);
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic gen(input int i, input bit allow_ror);
        pd[i] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 3))
            0:       psa[i] = 5'd0;
            1:       psa[i] = 5'd31;
            default: psa[i] = 5'($urandom);
        endcase
        pop[i]  = allow_ror ? 2'($urandom) : 2'($urandom_range(0, 2));
        pend[i] = 1'b1;
    endtask

    task automatic run_one(input string tag, input int r, input logic [31:0] d, input logic [4:0] sa,
                           input logic [1:0] op, input logic [31:0] exp_data, input int exp_lat);
        int k;
        pend[r] = 1'b1; pd[r] = d; psa[r] = sa; pop[r] = op;
        rsp_ready = 1'b1;
        k = 0;
        while (pend[r] && k < 20) begin step(); k++; end
        check({tag, "_acc"}, 32'(pend[r]), 32'd0);
        k = 0;
        do begin step(); k++; end while (!last_rv && k < 10);
        check({tag, "_lat"}, 32'(k - 1), 32'(exp_lat));
        check({tag, "_data"}, last_data, exp_data);
        check({tag, "_id"}, 32'(last_id), 32'(r));
    endtask

    task automatic drain();
        int k;
        k = 0;
        rsp_ready = 1'b1;
        while ((pend != '0 || m_phase != 0) && k < 40) begin step(); k++; end
        check("drain", 32'(m_phase), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) gen(i, 1'b1);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        pend = '0;
        rst  = 1'b0;

        // Directed shifts.
        run_one("sll31", 0, 32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, 1);
        run_one("sra4", 1, 32'h8000_0000, 5'd4, 2'd2, 32'hF800_0000, 1);
        run_one("srl4", 0, 32'h8000_0000, 5'd4, 2'd1, 32'h0800_0000, 1);
`ifdef SHIFT_ARB_ROR_EN
        run_one("ror8", 1, 32'h1234_5678, 5'd8, 2'd3, 32'h7812_3456, 2);
        run_one("ror0", 0, 32'h1234_5678, 5'd0, 2'd3, 32'h1234_5678, 2);
`else
        run_one("ror8", 1, 32'h1234_5678, 5'd8, 2'd3, 32'h0012_3456, 1);
        run_one("ror0", 0, 32'h1234_5678, 5'd0, 2'd3, 32'h1234_5678, 1);
`endif

        // Fairness: both requesters continuously valid from a reset pointer.
        rst = 1'b1; step(); rst = 1'b0;
        acc_q.delete(); acc_cyc.delete();
        rsp_ready = 1'b1;
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < NREQ; i++) if (!pend[i]) gen(i, 1'b0);
            step();
        end
        check("fair_count", 32'(acc_q.size() >= 4), 32'd1);
        if (acc_q.size() >= 4) begin
            for (int j = 0; j < 4; j++) check("fair_id", 32'(acc_q[j]), 32'(j % 2));
            for (int j = 1; j < 4; j++) check("fair_gap", 32'(acc_cyc[j] - acc_cyc[j-1]), 32'd3);
        end
        drain();

        // Backpressure: hold rsp_ready low while both requesters wait.
        rsp_ready = 1'b0;
        gen(0, 1'b0); gen(1, 1'b0);
        k = 0;
        do begin step(); k++; end while (!last_rv && k < 10);
        check("bp_valid", 32'(last_rv), 32'd1);
        repeat (4) step();
        check("bp_held", 32'(pend), 32'b10);
        rsp_ready = 1'b1;
        step();
        step();
        check("bp_next_acc", 32'(pend), 32'd0);
        drain();

        // Reset in the middle of a rotate; pointer must return to requester 0.
        rst = 1'b1; step(); rst = 1'b0;
        pend = '0;
        pend[0] = 1'b1; pd[0] = 32'hCAFE_F00D; psa[0] = 5'd12; pop[0] = 2'd3;
        step();
        check("mid_acc", 32'(pend[0]), 32'd0);
`ifdef SHIFT_ARB_ROR_EN
        step();
`endif
        rst = 1'b1;
        gen(0, 1'b0); gen(1, 1'b0);
        step();
        rst = 1'b0;
        check("mid_no_rsp", 32'(last_rv), 32'd0);
        acc_q.delete();
        step();
        check("mid_next_id", 32'(acc_q.size() == 1 && acc_q[0] == 0), 32'd1);
        drain();

        // Randomized traffic with occasional resets.
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < NREQ; i++) if (!pend[i] && $urandom_range(0, 1) == 1) gen(i, 1'b1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
